zoran_nios_gpio_pio: RTL and testbench

ZORAN_NIOS_GPIO_PIO -- requirements
Module: zoran_nios_gpio_pio

---
 rtl/zoran_nios_gpio_pio.sv | 146 ++++++++++++++
 tb/tb_zoran_nios_gpio_pio.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/zoran_nios_gpio_pio.sv
// Avalon-MM parallel I/O port with data/direction/mask/edge-capture registers
// and atomic bit set/clear access to the output data register.
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   address[2:0]         word address: 0 data, 1 direction, 2 irq mask,
//                        3 edge capture (W1C), 4 outset, 5 outclear
//   chipselect, write_n  write strobe = chipselect & ~write_n
//   writedata[31:0]      write data (bits above WIDTH-1 ignored)
//   readdata[31:0]       combinational read data, zero-extended
//   in_port              asynchronous pin inputs
//   out_port, oe_port    output data and per-bit output enable
//   irq                  registered level interrupt
module zoran_nios_gpio_pio #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
    parameter int unsigned           EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    // Upper write-data bits have no register behind them.
    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_wd;
            assign unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    // Edge detector selected at elaboration time.
    generate
        if (EDGE_TYPE == 1) begin : g_fall
            assign edge_det = ~sync & sync_d;
        end else if (EDGE_TYPE == 2) begin : g_any
            assign edge_det = sync ^ sync_d;
        end else begin : g_rise
            assign edge_det = sync & ~sync_d;
        end
    endgenerate

    assign cap_clr = (wr_en && address == ADDR_EDGE) ? wdata : '0;

    // Output data register with direct load plus atomic set/clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_out <= wdata;
                ADDR_OUTSET: data_out <= data_out | wdata;
                ADDR_OUTCLR: data_out <= data_out & ~wdata;
                default:     data_out <= data_out;
            endcase
        end
    end

    // Direction and interrupt mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            direction <= '0;
            irq_mask  <= '0;
        end else if (wr_en) begin
            if (address == ADDR_DIR)  direction <= wdata;
            if (address == ADDR_MASK) irq_mask  <= wdata;
        end
    end

    // Input synchronizer plus history flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync      <= '0;
            sync_d    <= '0;
        end else begin
            sync_meta <= in_port;
            sync      <= sync_meta;
            sync_d    <= sync;
        end
    end

    // Sticky edge capture; a new edge beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~cap_clr) | edge_det;
        end
    end

    // Interrupt follows capture/mask with one cycle of delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_capture & irq_mask);
        end
    end

    // Zero-latency read mux; data reads show driven bits or synchronized pins.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = (direction & data_out) | (~direction & sync);
            ADDR_DIR:  readdata[WIDTH-1:0] = direction;
            ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
            default:   readdata = '0;
        endcase
    end

    assign out_port = data_out;
    assign oe_port  = direction;

endmodule

// File: tb/tb_zoran_nios_gpio_pio.sv
module tb_zoran_nios_gpio_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        cs8 = 1'b0;
    logic        cs32 = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;

    logic [31:0] rd8;
    logic [7:0]  in8 = '0;
    logic [7:0]  out8;
    logic [7:0]  oe8;
    logic        irq8;

    logic [31:0] rd32;
    logic [31:0] in32 = '0;
    logic [31:0] out32;
    logic [31:0] oe32;
    logic        irq32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    zoran_nios_gpio_pio #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8),
        .write_n(write_n), .writedata(writedata), .readdata(rd8),
        .in_port(in8), .out_port(out8), .oe_port(oe8), .irq(irq8)
    );

    zoran_nios_gpio_pio #(.WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(2)) dut32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32),
        .write_n(write_n), .writedata(writedata), .readdata(rd32),
        .in_port(in32), .out_port(out32), .oe_port(oe32), .irq(irq32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel32, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs8       = ~sel32;
        cs32      = sel32;
        tick();
        write_n   = 1'b1;
        cs8       = 1'b0;
        cs32      = 1'b0;
    endtask

    task automatic rd8_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, rd8, exp);
    endtask

    task automatic rd32_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, rd32, exp);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out", 32'(out8), 32'hA5);
        check("rst_oe", 32'(oe8), 32'h00);
        check("rst_irq", 32'(irq8), 32'h0);
        rd8_chk("rst_cap", 3'd3, 32'h0);
        check("rst_out32", out32, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Data load, outset, outclear, direction and mixed data read
        wr(1'b0, 3'd0, 32'h0000_000F);
        wr(1'b0, 3'd4, 32'h0000_0030);
        wr(1'b0, 3'd5, 32'h0000_0003);
        check("set_clr_out", 32'(out8), 32'h3C);
        wr(1'b0, 3'd1, 32'hFFFF_FFF0);
        check("dir_oe", 32'(oe8), 32'hF0);
        check("dir_out_indep", 32'(out8), 32'h3C);
        in8 = 8'h05;
        tick(); tick(); tick();
        rd8_chk("read_mix", 3'd0, 32'h35);
        rd8_chk("read_dir", 3'd1, 32'hF0);
        rd8_chk("cap_05", 3'd3, 32'h05);
        check("irq_masked", 32'(irq8), 32'h0);
        wr(1'b0, 3'd3, 32'h0000_00FF);
        rd8_chk("cap_cleared", 3'd3, 32'h0);
        in8 = 8'h00;
        tick(); tick(); tick(); tick();
        rd8_chk("fall_ignored", 3'd3, 32'h0);

        // Rising edge capture and irq timing
        wr(1'b0, 3'd2, 32'h0000_0001);
        in8 = 8'h01;
        tick(); tick();
        rd8_chk("cap_not_yet", 3'd3, 32'h0);
        tick();
        rd8_chk("cap_set", 3'd3, 32'h01);
        check("irq_lag", 32'(irq8), 32'h0);
        tick();
        check("irq_high", 32'(irq8), 32'h1);
        in8 = 8'h00;
        tick(); tick(); tick(); tick();
        rd8_chk("cap_hold_fall", 3'd3, 32'h01);

        // Clear colliding with a new edge: set wins
        in8 = 8'h01;
        tick(); tick();
        wr(1'b0, 3'd3, 32'h0000_0001);
        rd8_chk("set_wins", 3'd3, 32'h01);
        check("set_wins_irq", 32'(irq8), 32'h1);
        tick();
        wr(1'b0, 3'd3, 32'h0000_0001);
        rd8_chk("clear_ok", 3'd3, 32'h0);
        check("irq_still", 32'(irq8), 32'h1);
        tick();
        check("irq_drop", 32'(irq8), 32'h0);

        // Undefined address writes and high-address reads
        wr(1'b0, 3'd6, 32'hFFFF_FFFF);
        wr(1'b0, 3'd7, 32'h0000_0000);
        check("a6_out", 32'(out8), 32'h3C);
        check("a6_oe", 32'(oe8), 32'hF0);
        rd8_chk("a6_mask", 3'd2, 32'h01);
        rd8_chk("read_a4", 3'd4, 32'h0);
        rd8_chk("read_a5", 3'd5, 32'h0);
        rd8_chk("read_mix2", 3'd0, 32'h31);

        // 32-bit any-edge instance
        in32 = 32'h8000_0000;
        tick(); tick(); tick();
        rd32_chk("w32_rise", 3'd3, 32'h8000_0000);
        wr(1'b1, 3'd3, 32'hFFFF_FFFF);
        rd32_chk("w32_clr", 3'd3, 32'h0);
        in32 = 32'h0;
        tick(); tick(); tick();
        rd32_chk("w32_fall", 3'd3, 32'h8000_0000);
        tick();
        check("w32_irq0", 32'(irq32), 32'h0);
        wr(1'b1, 3'd6, 32'hFFFF_FFFF);
        check("w32_a6_out", out32, 32'h0);
        check("w32_a6_oe", oe32, 32'h0);
        rd32_chk("w32_a6_mask", 3'd2, 32'h0);
        rd32_chk("w32_a6_cap", 3'd3, 32'h8000_0000);

        // Fill capture and raise irq, then async reset mid-cycle
        wr(1'b0, 3'd2, 32'h0000_00FF);
        in8 = 8'h00;
        tick(); tick(); tick();
        wr(1'b0, 3'd3, 32'h0000_00FF);
        in8 = 8'hFF;
        tick(); tick(); tick();
        rd8_chk("cap_ff", 3'd3, 32'hFF);
        tick();
        check("irq_ff", 32'(irq8), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_out", 32'(out8), 32'hA5);
        check("async_oe", 32'(oe8), 32'h00);
        check("async_irq", 32'(irq8), 32'h0);
        rd8_chk("async_cap", 3'd3, 32'h0);
        // Write presented while reset held is discarded
        wr(1'b0, 3'd0, 32'h0000_0000);
        check("rst_write_drop", 32'(out8), 32'hA5);
        reset_n = 1'b1;
        tick(); tick();
        rd8_chk("post_rst_wait", 3'd3, 32'h0);
        tick();
        rd8_chk("post_rst_rise", 3'd3, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
